// File: rtl/i2c_slave_core.sv
// I2C target engine: synchronizes SCL/SDA, detects START/STOP, matches a
// 7-bit address and moves bytes over tx/rx valid/ready ports.
// Ports: i2c_core_clk_i/reset_i (sync, active high); own_addr_i;
//   i2c_sda_i/i2c_scl_i line levels; i2c_sda_en_o/i2c_scl_en_o pull-low
//   enables; data_transmit_i/tx_valid_i/tx_ready_o read-byte source;
//   data_receive_o/rx_valid_o write-byte sink; rw_o, busy_o status;
//   stop_o, nack_o, underflow_o single-cycle event pulses.
// Option: define I2C_SLAVE_CLK_STRETCH_EN to stretch SCL on tx underflow
//   instead of sending 0xFF and pulsing underflow_o.
module i2c_slave_core #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 7
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 reset_i,
  input  logic [ADDR_SIZE-1:0] own_addr_i,
  input  logic                 i2c_sda_i,
  input  logic                 i2c_scl_i,
  output logic                 i2c_sda_en_o,
  output logic                 i2c_scl_en_o,
  input  logic [DATA_SIZE-1:0] data_transmit_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_SIZE-1:0] data_receive_o,
  output logic                 rx_valid_o,
  output logic                 rw_o,
  output logic                 busy_o,
  output logic                 stop_o,
  output logic                 nack_o,
  output logic                 underflow_o
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_SIZE);
  localparam logic [3:0] ADDR_LAST = 4'(DATA_SIZE - 1);

  // input conditioning
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic rise_q, fall_q, start_q, stop_q, sda_smp_q;

  // engine state
  state_t state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic [DATA_SIZE-1:0] sh_q, sh_n;
  logic [DATA_SIZE-1:0] tx_sh_q, tx_sh_n;
  logic [DATA_SIZE-1:0] tx_hold_q, tx_hold_n;
  logic [DATA_SIZE-1:0] rx_data_q, rx_data_n;
  logic tx_full_q, tx_full_n;
  logic rw_q, rw_n;
  logic busy_q, busy_n;
  logic sda_en_q, sda_en_n;
  logic scl_en_q, scl_en_n;
  logic stall_q, stall_n;
  logic ack_ok_q, ack_ok_n;
  logic rx_valid_q, rx_valid_n;
  logic stop_p_q, stop_p_n;
  logic nack_q, nack_n;
  logic uflow_q, uflow_n;

  logic hs;
  logic has_byte;
  logic need;
  logic [DATA_SIZE-1:0] ld_byte;

  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_d     <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_d     <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      sda_smp_q <= 1'b1;
    end else begin
      scl_s1    <= i2c_scl_i;
      scl_s2    <= scl_s1;
      scl_d     <= scl_s2;
      sda_s1    <= i2c_sda_i;
      sda_s2    <= sda_s1;
      sda_d     <= sda_s2;
      rise_q    <= scl_s2 & ~scl_d;
      fall_q    <= ~scl_s2 & scl_d;
      start_q   <= scl_s2 & scl_d & ~sda_s2 & sda_d;
      stop_q    <= scl_s2 & scl_d & sda_s2 & ~sda_d;
      sda_smp_q <= sda_d;
    end
  end

  assign tx_ready_o = ~tx_full_q &
                      (((state_q == ADDR_ACK) & rw_q) |
                       ((state_q == READ_ACK) & ack_ok_q));
  assign hs       = tx_valid_i & tx_ready_o;
  assign has_byte = tx_full_q | hs;
  assign ld_byte  = tx_full_q ? tx_hold_q : data_transmit_i;

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    sh_n       = sh_q;
    tx_sh_n    = tx_sh_q;
    tx_hold_n  = tx_hold_q;
    tx_full_n  = tx_full_q;
    rx_data_n  = rx_data_q;
    rw_n       = rw_q;
    busy_n     = busy_q;
    sda_en_n   = sda_en_q;
    scl_en_n   = scl_en_q;
    stall_n    = stall_q;
    ack_ok_n   = ack_ok_q;
    rx_valid_n = 1'b0;
    stop_p_n   = 1'b0;
    nack_n     = 1'b0;
    uflow_n    = 1'b0;
    need       = 1'b0;

    if (hs) begin
      tx_hold_n = data_transmit_i;
      tx_full_n = 1'b1;
    end

    if (stop_q) begin
      state_n  = IDLE;
      cnt_n    = '0;
      busy_n   = 1'b0;
      sda_en_n = 1'b0;
      scl_en_n = 1'b0;
      stall_n  = 1'b0;
      ack_ok_n = 1'b0;
      stop_p_n = busy_q;
    end else if (start_q) begin
      state_n  = ADDR;
      cnt_n    = '0;
      busy_n   = 1'b0;
      sda_en_n = 1'b0;
      scl_en_n = 1'b0;
      stall_n  = 1'b0;
      ack_ok_n = 1'b0;
    end else if (stall_q) begin
      // SCL held low: MSB goes out with the handshake, SCL follows a cycle later
      if (has_byte) begin
        tx_sh_n   = ld_byte;
        sda_en_n  = ~ld_byte[DATA_SIZE-1];
        tx_full_n = 1'b0;
        stall_n   = 1'b0;
        state_n   = READ;
        cnt_n     = 4'd1;
      end
    end else begin
      if (scl_en_q) scl_en_n = 1'b0;
      unique case (state_q)
        ADDR: begin
          if (rise_q) begin
            sh_n  = {sh_q[DATA_SIZE-2:0], sda_smp_q};
            cnt_n = cnt_q + 4'd1;
            if (cnt_q == ADDR_LAST) begin
              if (sh_q[ADDR_SIZE-1:0] == own_addr_i) begin
                state_n = ADDR_ACK;
                rw_n    = sda_smp_q;
                busy_n  = 1'b1;
              end else begin
                state_n = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK, WRITE_ACK: begin
          // first fall opens the ACK slot, second fall closes it
          if (fall_q) begin
            if (!sda_en_q) begin
              sda_en_n = 1'b1;
            end else begin
              sda_en_n = 1'b0;
              cnt_n    = '0;
              if (state_q == WRITE_ACK || !rw_q) state_n = WRITE;
              else need = 1'b1;
            end
          end
        end
        WRITE: begin
          if (cnt_q == LAST_BIT) begin
            rx_data_n  = sh_q;
            rx_valid_n = 1'b1;
            state_n    = WRITE_ACK;
          end else if (rise_q) begin
            sh_n  = {sh_q[DATA_SIZE-2:0], sda_smp_q};
            cnt_n = cnt_q + 4'd1;
          end
        end
        READ: begin
          if (fall_q) begin
            if (cnt_q == LAST_BIT) begin
              sda_en_n = 1'b0;
              ack_ok_n = 1'b0;
              state_n  = READ_ACK;
            end else begin
              tx_sh_n  = {tx_sh_q[DATA_SIZE-2:0], 1'b0};
              sda_en_n = ~tx_sh_q[DATA_SIZE-2];
              cnt_n    = cnt_q + 4'd1;
            end
          end
        end
        READ_ACK: begin
          if (rise_q && !ack_ok_q) begin
            if (sda_smp_q) begin
              nack_n  = 1'b1;
              state_n = WAIT_STOP;
            end else begin
              ack_ok_n = 1'b1;
            end
          end else if (fall_q && ack_ok_q) begin
            need = 1'b1;
          end
        end
        default: begin
        end
      endcase

      if (need) begin
        ack_ok_n = 1'b0;
        if (has_byte) begin
          tx_sh_n   = ld_byte;
          sda_en_n  = ~ld_byte[DATA_SIZE-1];
          tx_full_n = 1'b0;
          state_n   = READ;
          cnt_n     = 4'd1;
        end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          ack_ok_n = ack_ok_q;
          scl_en_n = 1'b1;
          stall_n  = 1'b1;
`else
          tx_sh_n  = '1;
          sda_en_n = 1'b0;
          uflow_n  = 1'b1;
          state_n  = READ;
          cnt_n    = 4'd1;
`endif
        end
      end
    end
  end

  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      tx_sh_q    <= '0;
      tx_hold_q  <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_en_q   <= 1'b0;
      scl_en_q   <= 1'b0;
      stall_q    <= 1'b0;
      ack_ok_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      stop_p_q   <= 1'b0;
      nack_q     <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      sh_q       <= sh_n;
      tx_sh_q    <= tx_sh_n;
      tx_hold_q  <= tx_hold_n;
      tx_full_q  <= tx_full_n;
      rx_data_q  <= rx_data_n;
      rw_q       <= rw_n;
      busy_q     <= busy_n;
      sda_en_q   <= sda_en_n;
      scl_en_q   <= scl_en_n;
      stall_q    <= stall_n;
      ack_ok_q   <= ack_ok_n;
      rx_valid_q <= rx_valid_n;
      stop_p_q   <= stop_p_n;
      nack_q     <= nack_n;
      uflow_q    <= uflow_n;
    end
  end

  assign i2c_sda_en_o   = sda_en_q;
  assign i2c_scl_en_o   = scl_en_q;
  assign data_receive_o = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rw_o           = rw_q;
  assign busy_o         = busy_q;
  assign stop_o         = stop_p_q;
  assign nack_o         = nack_q;
  assign underflow_o    = uflow_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bit-banged I2C master on open-drain lines,
// table of write transactions plus read, underflow, repeated-start, reset.
module tb_i2c_slave_core;

  logic clk = 1'b0;
  logic reset_i;
  logic [6:0] own_addr;
  logic sda_m, scl_m;
  logic sda_bus, scl_bus;
  logic sda_en, scl_en;
  logic [7:0] data_transmit;
  logic tx_valid, tx_ready;
  logic [7:0] data_receive;
  logic rx_valid, rw, busy, stop_p, nack_p, uflow;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_en;
  assign scl_bus = scl_m & ~scl_en;

  i2c_slave_core dut (
    .i2c_core_clk_i (clk),
    .reset_i        (reset_i),
    .own_addr_i     (own_addr),
    .i2c_sda_i      (sda_bus),
    .i2c_scl_i      (scl_bus),
    .i2c_sda_en_o   (sda_en),
    .i2c_scl_en_o   (scl_en),
    .data_transmit_i(data_transmit),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .data_receive_o (data_receive),
    .rx_valid_o     (rx_valid),
    .rw_o           (rw),
    .busy_o         (busy),
    .stop_o         (stop_p),
    .nack_o         (nack_p),
    .underflow_o    (uflow)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int hs_count = 0;
  int rx_cnt = 0, stop_cnt = 0, nack_cnt = 0, uf_cnt = 0;
  int busy_cyc = 0, sda_cyc = 0, scl_cyc = 0;
  logic [7:0] rx_log [0:63];

  // producer controls, written only by the main sequence
  logic [7:0] tx_bytes [0:3];
  int tx_n = 0, tx_base = 0, tx_go = 0;

  always @(posedge clk) begin
    cyc++;
    if (tx_valid && tx_ready) hs_count++;
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_cnt < 64) rx_log[rx_cnt] = data_receive;
      rx_cnt++;
    end
    if (stop_p) stop_cnt++;
    if (nack_p) nack_cnt++;
    if (uflow) uf_cnt++;
    if (busy) busy_cyc++;
    if (sda_en) sda_cyc++;
    if (scl_en) scl_cyc++;
  end

  initial begin
    int idx;
    tx_valid = 1'b0;
    data_transmit = 8'h00;
    forever begin
      @(negedge clk);
      idx = hs_count - tx_base;
      if (idx >= 0 && idx < tx_n && cyc >= tx_go) begin
        tx_valid = 1'b1;
        data_transmit = tx_bytes[idx];
      end else begin
        tx_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int n;
    n = 0;
    scl_m = 1'b1;
    wait_cyc(1);
    while (scl_bus !== 1'b1 && n < 400) begin
      wait_cyc(1);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL scl_release held=%0d required<400", n);
    end
  endtask

  task automatic send_bit(input logic b);
    wait_cyc(2);
    sda_m = b;
    wait_cyc(6);
    scl_high();
    wait_cyc(8);
    scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_cyc(2);
    sda_m = 1'b1;
    wait_cyc(6);
    scl_high();
    wait_cyc(4);
    b = sda_bus;
    wait_cyc(4);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wait_cyc(2);
    sda_m = 1'b1;
    wait_cyc(6);
    scl_high();
    wait_cyc(8);
    sda_m = 1'b0;
    wait_cyc(8);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(2);
    sda_m = 1'b0;
    wait_cyc(6);
    scl_high();
    wait_cyc(8);
    sda_m = 1'b1;
    wait_cyc(8);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~m_ack);
  endtask

  typedef struct {
    logic [7:0] abyte;
    logic [7:0] dbyte;
    logic       ack_a;
    logic       ack_d;
    int         rx_n;
    logic [7:0] rx;
    int         stop_n;
    logic       busy_seen;
  } vec_t;

  initial begin
    vec_t vt [5];
    logic a, d, b;
    logic [7:0] rd;
    int r0, s0, b0, d0, n0, u0, c0, dl;
    logic [7:0] exp_rd;
    int exp_uf;

    vt[0] = '{8'h78, 8'hA5, 1'b1, 1'b1, 1, 8'hA5, 1, 1'b1};
    vt[1] = '{8'h78, 8'h00, 1'b1, 1'b1, 1, 8'h00, 1, 1'b1};
    vt[2] = '{8'h7A, 8'hFF, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0};
    vt[3] = '{8'h38, 8'h55, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0};
    vt[4] = '{8'h78, 8'h81, 1'b1, 1'b1, 1, 8'h81, 1, 1'b1};

    reset_i = 1'b1;
    own_addr = 7'h3C;
    sda_m = 1'b1;
    scl_m = 1'b1;
    wait_cyc(4);
    check("reset_outputs",
          {sda_en, scl_en, tx_ready, data_receive, rx_valid, rw, busy,
           stop_p, nack_p, uflow}, 32'h0);
    reset_i = 1'b0;
    wait_cyc(10);
    check("idle_busy", busy, 1'b0);

    for (int i = 0; i < 5; i++) begin
      r0 = rx_cnt; s0 = stop_cnt; b0 = busy_cyc; d0 = sda_cyc;
      i2c_start();
      write_byte(vt[i].abyte, a);
      write_byte(vt[i].dbyte, d);
      i2c_stop();
      wait_cyc(4);
      check($sformatf("v%0d_addr_ack", i), a, vt[i].ack_a);
      check($sformatf("v%0d_data_ack", i), d, vt[i].ack_d);
      check($sformatf("v%0d_rx_pulses", i), rx_cnt - r0, vt[i].rx_n);
      check($sformatf("v%0d_rx_data", i), data_receive, vt[i].rx);
      check($sformatf("v%0d_stop_pulses", i), stop_cnt - s0, vt[i].stop_n);
      check($sformatf("v%0d_busy_seen", i), busy_cyc > b0, vt[i].busy_seen);
      check($sformatf("v%0d_sda_pulled", i), sda_cyc > d0, vt[i].ack_a);
      check($sformatf("v%0d_busy_end", i), busy, 1'b0);
    end

    // one write transaction carrying two data bytes
    r0 = rx_cnt; s0 = stop_cnt;
    i2c_start();
    write_byte(8'h78, a);
    check("w2_addr_ack", a, 1'b1);
    check("w2_rw", rw, 1'b0);
    write_byte(8'hA5, a);
    check("w2_ack1", a, 1'b1);
    write_byte(8'h5A, a);
    check("w2_ack2", a, 1'b1);
    i2c_stop();
    wait_cyc(4);
    check("w2_rx_pulses", rx_cnt - r0, 2);
    check("w2_rx0", rx_log[r0], 8'hA5);
    check("w2_rx1", rx_log[r0+1], 8'h5A);
    check("w2_stop", stop_cnt - s0, 1);
    check("w2_busy_end", busy, 1'b0);

    // read two preloaded bytes, ACK then NACK
    tx_bytes[0] = 8'h12; tx_bytes[1] = 8'h34;
    tx_base = hs_count; tx_go = 0; tx_n = 2;
    n0 = nack_cnt; s0 = stop_cnt;
    i2c_start();
    write_byte(8'h79, a);
    check("rd_addr_ack", a, 1'b1);
    check("rd_rw", rw, 1'b1);
    read_byte(1'b1, rd);
    check("rd_byte0", rd, 8'h12);
    read_byte(1'b0, rd);
    check("rd_byte1", rd, 8'h34);
    wait_cyc(4);
    check("rd_nack", nack_cnt - n0, 1);
    check("rd_wait_busy", busy, 1'b1);
    check("rd_wait_sda", sda_en, 1'b0);
    i2c_stop();
    wait_cyc(4);
    check("rd_stop", stop_cnt - s0, 1);
    tx_n = 0;

    // read with a late tx byte
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    exp_rd = 8'hC3;
    exp_uf = 0;
`else
    exp_rd = 8'hFF;
    exp_uf = 1;
`endif
    tx_bytes[0] = 8'hC3;
    tx_base = hs_count; tx_go = 0; tx_n = 0;
    u0 = uf_cnt; c0 = scl_cyc;
    i2c_start();
    write_byte(8'h79, a);
    check("uf_addr_ack", a, 1'b1);
    tx_go = cyc + 20;
    tx_n = 1;
    read_byte(1'b0, rd);
    check("uf_byte", rd, exp_rd);
    check("uf_pulses", uf_cnt - u0, exp_uf);
    dl = scl_cyc - c0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    check("uf_stretch_len", (dl >= 12 && dl <= 25), 1'b1);
`else
    check("uf_stretch_len", dl, 0);
`endif
    i2c_stop();
    tx_n = 0;
    wait_cyc(4);

    // write, then repeated START into a read
    tx_bytes[0] = 8'h66;
    tx_base = hs_count; tx_go = 0; tx_n = 1;
    r0 = rx_cnt;
    i2c_start();
    write_byte(8'h78, a);
    check("rs_addr_ack", a, 1'b1);
    write_byte(8'h11, a);
    check("rs_data_ack", a, 1'b1);
    i2c_start();
    check("rs_rx_data", data_receive, 8'h11);
    check("rs_rx_pulses", rx_cnt - r0, 1);
    check("rs_busy_cleared", busy, 1'b0);
    write_byte(8'h79, a);
    check("rs_addr2_ack", a, 1'b1);
    check("rs_rw", rw, 1'b1);
    check("rs_busy", busy, 1'b1);
    read_byte(1'b0, rd);
    check("rs_read", rd, 8'h66);
    i2c_stop();
    tx_n = 0;
    wait_cyc(4);

    // reset in the middle of a read byte with SDA held low
    tx_bytes[0] = 8'h00;
    tx_base = hs_count; tx_go = 0; tx_n = 1;
    i2c_start();
    write_byte(8'h79, a);
    check("rst_addr_ack", a, 1'b1);
    for (int i = 0; i < 4; i++) recv_bit(b);
    wait_cyc(6);
    check("rst_sda_before", sda_en, 1'b1);
    reset_i = 1'b1;
    wait_cyc(1);
    check("rst_sda_after", sda_en, 1'b0);
    check("rst_outputs",
          {sda_en, scl_en, tx_ready, data_receive, rx_valid, rw, busy,
           stop_p, nack_p, uflow}, 32'h0);
    tx_n = 0;
    wait_cyc(2);
    reset_i = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_cyc(10);

    // block answers normally after the reset
    i2c_start();
    write_byte(8'h78, a);
    check("post_addr_ack", a, 1'b1);
    write_byte(8'h3C, a);
    check("post_data_ack", a, 1'b1);
    i2c_stop();
    wait_cyc(4);
    check("post_rx", data_receive, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
